// File: rtl/data_ram_dp_param.sv
// Parametrised dual-port data RAM: write port A, read port B, hardware clear after reset.
// Build option: define DATA_RAM_BYPASS_EN to forward a same-cycle port A write to port B.
module data_ram_dp_param #(
  parameter int unsigned       DATA_W    = 8,
  parameter int unsigned       ADDR_W    = 5,
  parameter int unsigned       DEPTH     = 32,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0,
  parameter bit                READ_REG  = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_A,
  input  logic              wr_A,
  input  logic [ADDR_W-1:0] adrs_A,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rd_en_B,
  input  logic [ADDR_W-1:0] adrs_B,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_B,
  output logic              ready,
  output logic              err_A
);

`ifdef DATA_RAM_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  localparam int unsigned       IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  // state is the FSM observation point; ready mirrors state == ST_RUN.
  state_e state;
  state_e state_nxt;
  logic   clr_we;

  logic [ADDR_W-1:0] clr_ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              a_in_range;
  logic              b_in_range;
  logic              wr_req;
  logic              wr_ok;
  logic              bypass_hit;
  logic [DATA_W-1:0] b_word;
  logic [DATA_W-1:0] rd_word;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_CLEAR;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (state == ST_CLEAR && clr_ptr == LAST_ADDR) begin
      state_nxt = ST_RUN;
    end
  end

  always_comb begin
    ready  = (state == ST_RUN);
    clr_we = (state == ST_CLEAR) && !rst;
  end

  // The pointer parks on the last word once the clear completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_ptr <= '0;
    end else if (clr_we && clr_ptr != LAST_ADDR) begin
      clr_ptr <= clr_ptr + ADDR_W'(1);
    end
  end

  always_comb begin
    a_in_range = ({1'b0, adrs_A} < DEPTH_X);
    b_in_range = ({1'b0, adrs_B} < DEPTH_X);
    wr_req     = en_A && wr_A;
    wr_ok      = wr_req && ready && a_in_range;
    bypass_hit = BYPASS && wr_ok && (adrs_A == adrs_B);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_A <= 1'b0;
    end else begin
      err_A <= wr_req && (!ready || !a_in_range);
    end
  end

  // Clear and port A writes are exclusive: writes require ST_RUN.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_ptr[IDX_W-1:0]] <= CLEAR_VAL;
    end else if (wr_ok) begin
      mem[adrs_A[IDX_W-1:0]] <= data_in;
    end
  end

  always_comb begin
    b_word  = b_in_range ? mem[adrs_B[IDX_W-1:0]] : CLEAR_VAL;
    rd_word = bypass_hit ? data_in : b_word;
  end

  // Port B handshake: with READ_REG=1 a request accepted at an edge (rd_en_B high
  // while ready) produces data_out with valid_B high for exactly the next cycle;
  // with READ_REG=0 data_out is always current and valid_B is tied high.
  if (READ_REG) begin : g_reg_read
    logic [DATA_W-1:0] dout_q;
    logic              vld_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        dout_q <= '0;
        vld_q  <= 1'b0;
      end else begin
        vld_q <= rd_en_B && ready;
        if (rd_en_B && ready) begin
          dout_q <= rd_word;
        end
      end
    end

    assign data_out = dout_q;
    assign valid_B  = vld_q;
  end else begin : g_comb_read
    logic unused_rd_en;

    assign unused_rd_en = rd_en_B;
    assign data_out     = rd_word;
    assign valid_B      = 1'b1;
  end

endmodule

// File: tb/tb_data_ram_dp_param.sv
// Scoreboard bench: one combinational-read instance (CLEAR_VAL=A5) and one
// registered-read instance (CLEAR_VAL=00) share the same stimulus.
module tb_data_ram_dp_param;

  localparam int DEPTH = 25;
`ifdef DATA_RAM_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic       chk;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       en_A;
  logic       wr_A;
  logic [4:0] adrs_A;
  logic [7:0] data_in;
  logic       rd_en_B;
  logic [4:0] adrs_B;

  logic [7:0] c_data;
  logic       c_valid;
  logic       c_ready;
  logic       c_err;
  logic [7:0] r_data;
  logic       r_valid;
  logic       r_ready;
  logic       r_err;

  int checks   = 0;
  int failures = 0;
  bit mon_en   = 1'b0;

  // Reference model: word values, whether each word holds a known value yet,
  // words cleared since the last reset, and expected port B register contents.
  logic [7:0] mem_c [DEPTH];
  logic [7:0] mem_r [DEPTH];
  bit         known [DEPTH];
  int         m_cleared = 0;
  bit         m_ready   = 1'b0;
  bit         m_err     = 1'b0;
  bit         m_vld     = 1'b0;
  logic [7:0] m_hold    = 8'h00;

  exp_t       exp_c_q   [$];
  logic [7:0] exp_r_q   [$];
  logic       exp_rdy_q [$];
  logic       exp_err_q [$];

  always #5 clk = ~clk;

  data_ram_dp_param #(
    .DATA_W(8), .ADDR_W(5), .DEPTH(DEPTH), .CLEAR_VAL(8'hA5), .READ_REG(1'b0)
  ) u_comb (
    .clk(clk), .rst(rst), .en_A(en_A), .wr_A(wr_A), .adrs_A(adrs_A),
    .data_in(data_in), .rd_en_B(rd_en_B), .adrs_B(adrs_B),
    .data_out(c_data), .valid_B(c_valid), .ready(c_ready), .err_A(c_err)
  );

  data_ram_dp_param #(
    .DATA_W(8), .ADDR_W(5), .DEPTH(DEPTH), .CLEAR_VAL(8'h00), .READ_REG(1'b1)
  ) u_reg (
    .clk(clk), .rst(rst), .en_A(en_A), .wr_A(wr_A), .adrs_A(adrs_A),
    .data_in(data_in), .rd_en_B(rd_en_B), .adrs_B(adrs_B),
    .data_out(r_data), .valid_B(r_valid), .ready(r_ready), .err_A(r_err)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Driver: one clock cycle of stimulus plus the matching model update.
  task automatic step(input bit r, input bit en, input bit wr, input logic [4:0] aa,
                      input logic [7:0] di, input bit rd, input logic [4:0] ab);
    bit         wok;
    bit         hit;
    bit         acc;
    bit         errn;
    logic [7:0] rword;
    exp_t       ce;
    rst     = r;
    en_A    = en;
    wr_A    = wr;
    adrs_A  = aa;
    data_in = di;
    rd_en_B = rd;
    adrs_B  = ab;
    wok  = en && wr && m_ready && (int'(aa) < DEPTH);
    hit  = BYP && wok && (aa == ab);
    errn = !r && en && wr && (!m_ready || int'(aa) >= DEPTH);
    acc  = !r && rd && m_ready;
    if (int'(ab) >= DEPTH) begin
      ce.chk = 1'b1; ce.data = 8'hA5; rword = 8'h00;
    end else if (hit) begin
      ce.chk = 1'b1; ce.data = di; rword = di;
    end else begin
      ce.chk = known[ab]; ce.data = mem_c[ab]; rword = mem_r[ab];
    end
    exp_c_q.push_back(ce);
    exp_rdy_q.push_back(m_ready);
    exp_err_q.push_back(m_err);
    if (acc) exp_r_q.push_back(rword);
    @(posedge clk);
    #1;
    if (wok) begin
      mem_c[aa] = di;
      mem_r[aa] = di;
      known[aa] = 1'b1;
    end
    if (r) begin
      m_cleared = 0;
      m_ready   = 1'b0;
    end else if (!m_ready) begin
      mem_c[m_cleared] = 8'hA5;
      mem_r[m_cleared] = 8'h00;
      known[m_cleared] = 1'b1;
      m_cleared++;
      m_ready = (m_cleared == DEPTH);
    end
    m_err = errn;
    m_vld = acc;
    if (acc) m_hold = rword;
    if (r) m_hold = 8'h00;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 5'd0);
  endtask

  // Monitor: pops one expectation set per cycle, and a read response whenever valid_B is high.
  always @(negedge clk) begin
    exp_t       ce;
    logic       er;
    logic       rd;
    logic [7:0] rv;
    if (mon_en && exp_c_q.size() > 0) begin
      ce = exp_c_q.pop_front();
      rd = exp_rdy_q.pop_front();
      er = exp_err_q.pop_front();
      if (ce.chk) check("comb_data", c_data, ce.data);
      check("comb_valid", c_valid, 1'b1);
      check("comb_ready", c_ready, rd);
      check("reg_ready", r_ready, rd);
      check("comb_err", c_err, er);
      check("reg_err", r_err, er);
      check("reg_valid", r_valid, m_vld);
      if (r_valid === 1'b1) begin
        if (exp_r_q.size() == 0) begin
          check("reg_unexpected_resp", 1'b1, 1'b0);
        end else begin
          rv = exp_r_q.pop_front();
          check("reg_data", r_data, rv);
        end
      end else begin
        check("reg_hold", r_data, m_hold);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      known[i] = 1'b0;
      mem_c[i] = 8'h00;
      mem_r[i] = 8'h00;
    end
    rst = 1'b1; en_A = 1'b0; wr_A = 1'b0; adrs_A = '0;
    data_in = '0; rd_en_B = 1'b0; adrs_B = '0;
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b1;

    // Reset then full clear; a write during CLEAR is rejected.
    repeat (3) step(1'b1, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 5'd0);
    for (int i = 0; i < 27; i++)
      step(1'b0, (i == 4), (i == 4), 5'd2, 8'h77, 1'b1, 5'($urandom_range(0, 31)));
    for (int i = 0; i < 32; i++) step(1'b0, 1'b0, 1'b0, 5'd0, 8'h00, 1'b1, 5'(i));

    // Registered read of a fresh write, then an idle cycle that must hold data.
    step(1'b0, 1'b1, 1'b1, 5'd5, 8'h3C, 1'b0, 5'd0);
    step(1'b0, 1'b0, 1'b0, 5'd0, 8'h00, 1'b1, 5'd5);
    idle(2);

    // Last valid word versus first invalid address.
    step(1'b0, 1'b1, 1'b1, 5'd24, 8'hFF, 1'b0, 5'd0);
    step(1'b0, 1'b1, 1'b1, 5'd25, 8'h11, 1'b0, 5'd0);
    step(1'b0, 1'b0, 1'b0, 5'd0, 8'h00, 1'b1, 5'd24);
    step(1'b0, 1'b0, 1'b0, 5'd0, 8'h00, 1'b1, 5'd25);
    step(1'b0, 1'b0, 1'b0, 5'd0, 8'h00, 1'b1, 5'd31);

    // Same-address write and read collision.
    step(1'b0, 1'b1, 1'b1, 5'd7, 8'h12, 1'b0, 5'd0);
    step(1'b0, 1'b1, 1'b1, 5'd7, 8'h5A, 1'b1, 5'd7);
    step(1'b0, 1'b0, 1'b0, 5'd0, 8'h00, 1'b1, 5'd7);

    // Combinational read follows a write one cycle later; out-of-range write ignored.
    step(1'b0, 1'b1, 1'b1, 5'd0, 8'h81, 1'b1, 5'd0);
    step(1'b0, 1'b0, 1'b0, 5'd0, 8'h00, 1'b1, 5'd0);
    step(1'b0, 1'b1, 1'b1, 5'd31, 8'h42, 1'b0, 5'd31);
    idle(2);

    // Reset mid-clear restarts the sequence from word 0.
    step(1'b1, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 5'd0);
    idle(10);
    step(1'b1, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 5'd0);
    for (int i = 0; i < 28; i++)
      step(1'b0, (i == 3), (i == 3), 5'd2, 8'h77, 1'b1, 5'(i % 25));
    step(1'b0, 1'b0, 1'b0, 5'd0, 8'h00, 1'b1, 5'd2);

    // Randomised traffic with occasional collisions and resets.
    for (int i = 0; i < 500; i++) begin
      logic [4:0] aa;
      logic [4:0] ab;
      aa = 5'($urandom_range(0, 31));
      ab = ($urandom_range(0, 3) == 0) ? aa : 5'($urandom_range(0, 31));
      step(($urandom_range(0, 149) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           aa, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), ab);
    end
    idle(30);

    check("resp_queue_empty", exp_r_q.size(), 0);
    check("exp_queue_empty", exp_c_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_ram_dp_param.md
Name: data_ram_dp_param

Overview:
- Parametrised successor to the existing 8-bit x 32 data RAM: one write port (A), one read port (B), configurable width, depth and read mode.
- Adds hardware memory clear after reset, a ready flag, an out-of-range write error pulse, and an optional registered read with valid.
- Sits between the CPU datapath (stores on port A) and load/operand fetch (port B); drop-in compatible with the old RAM when READ_REG=0.

Parameters:
- DATA_W, 8, data word width in bits.
- ADDR_W, 5, address width in bits.
- DEPTH, 32, implemented words; must satisfy 2 <= DEPTH <= 2**ADDR_W; valid addresses are 0..DEPTH-1.
- CLEAR_VAL, 0, value written to every word during the post-reset clear (DATA_W bits).
- READ_REG, 0, 0 = combinational read; 1 = registered read, 1-cycle latency, with valid_B.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- en_A  in  1  port A enable.
- wr_A  in  1  port A write strobe; a write occurs only when en_A & wr_A & ready.
- adrs_A  in  ADDR_W  port A write address.
- data_in  in  DATA_W  port A write data.
- rd_en_B  in  1  port B read request; used only when READ_REG=1.
- adrs_B  in  ADDR_W  port B read address.
- data_out  out  DATA_W  port B read data.
- valid_B  out  1  read-data-valid; READ_REG=1 only, tied 1 when READ_REG=0.
- ready  out  1  high once the clear sequence is complete.
- err_A  out  1  one-cycle pulse on a rejected write.

Behaviour:
- Reset: while rst=1 → state=CLEAR, clr_ptr=0, ready=0, err_A=0, valid_B=0. When READ_REG=1, data_out register=0. Memory contents are not changed by rst itself.
- FSM states: CLEAR, RUN.
  - CLEAR: each cycle with rst=0 writes CLEAR_VAL to mem[clr_ptr], then clr_ptr+1. The cycle that writes clr_ptr=DEPTH-1 moves the state to RUN.
  - ready=1 from the first cycle in RUN, so ready rises exactly DEPTH cycles after rst falls.
  - RUN: stays in RUN until rst is asserted again.
  - rst asserted mid-CLEAR or in RUN → back to CLEAR, clr_ptr=0; the clear restarts from word 0.
- Writes (RUN only): en_A & wr_A & adrs_A<DEPTH → mem[adrs_A] <= data_in at the posedge.
- err_A is registered and goes high for the next cycle when en_A & wr_A and either:
  - state=CLEAR; the write is dropped; or
  - adrs_A>=DEPTH; the write is dropped.
- Read, READ_REG=0:
  - data_out = mem[adrs_B] combinationally; = CLEAR_VAL if adrs_B>=DEPTH.
  - Valid in any state; during CLEAR, words not yet cleared return their stale content.
- Read, READ_REG=1:
  - rd_en_B=1 at edge N → data_out loaded at edge N, visible in cycle N+1 with valid_B=1 for that one cycle.
  - Back-to-back requests give continuous valid_B.
  - rd_en_B=0 → valid_B=0 and data_out holds its last value.
  - rd_en_B during CLEAR is ignored: valid_B=0.
  - adrs_B>=DEPTH returns CLEAR_VAL with valid_B=1.
- Same-address write and read in the same cycle (no bypass):
  - READ_REG=1 returns the old word.
  - READ_REG=0 shows the new word from the cycle after the edge.
- Widths: all address compares are unsigned ADDR_W-bit. clr_ptr is ADDR_W bits and never wraps past DEPTH-1.

Optional Feature:
- DATA_RAM_BYPASS_EN. When defined, a same-cycle write to adrs_B (en_A & wr_A & ready & adrs_A==adrs_B<DEPTH) is forwarded to port B:
  - READ_REG=0: data_out = data_in combinationally that cycle.
  - READ_REG=1: the registered read captures data_in (new data).
- Not defined: behaviour exactly as in Behaviour (old data on collision).

Test Plan (DATA_W=8, ADDR_W=5, DEPTH=25, CLEAR_VAL=8'h00 unless noted):
- rst high 3 cycles then low → ready=0 for 25 cycles, ready=1 on cycle 26; read every adrs 0..24 → 8'h00. Repeat with CLEAR_VAL=8'hA5 → all 8'hA5.
- READ_REG=1, ready: write 8'h3C @5; next cycle rd_en_B=1 adrs_B=5 → following cycle data_out=8'h3C, valid_B=1; the cycle after with rd_en_B=0 → valid_B=0, data_out still 8'h3C.
- Write 8'hFF @24 then 8'h11 @25 → err_A pulses once only for @25; read @24=8'hFF, read @25=8'h00.
- Assert rst at clear cycle 10, release after 1 cycle → ready rises exactly 25 cycles after release. A write of 8'h77 @2 issued during CLEAR → err_A=1, @2 reads 8'h00.
- READ_REG=1: write 8'h5A @7 and rd_en_B @7 in the same cycle, mem[7] previously 8'h12 → data_out=8'h12 without DATA_RAM_BYPASS_EN, 8'h5A with it; next read @7 =8'h5A in both builds.
- READ_REG=0, rst=0 throughout: write 8'h81 @0 → data_out with adrs_B=0 shows 8'h81 the cycle after the edge; write 8'h42 @31 → ignored, err_A=1.
